// File: rtl/screen_rom_reader_if.sv
// Scan-position, ROM and pixel-output signals of the screen ROM reader.
// The master drives the scan and ROM data; the slave is the reader itself.
interface screen_rom_reader_if #(
  parameter int ADDR_W = 17
);
  logic              i_pix_en;
  logic              i_active;
  logic [9:0]        i_x;
  logic [9:0]        i_y;
  logic              i_frame_start;
  logic [ADDR_W-1:0] o_addr;
  logic [7:0]        i_rom_data;
  logic [7:0]        o_pixel;
  logic              o_pixel_valid;
  logic              o_frame_done;

  modport master (
    output i_pix_en, i_active, i_x, i_y, i_frame_start, i_rom_data,
    input  o_addr, o_pixel, o_pixel_valid, o_frame_done
  );

  modport slave (
    input  i_pix_en, i_active, i_x, i_y, i_frame_start, i_rom_data,
    output o_addr, o_pixel, o_pixel_valid, o_frame_done
  );
endinterface

// File: rtl/screen_rom_reader.sv
// Raster-side screen ROM reader: maps in-window scan positions to row-major ROM
// addresses and registers the returned byte. Colour keying: SCREEN_ROM_READER_TRANSP_EN.
module screen_rom_reader #(
  parameter int         IMG_W     = 471,
  parameter int         IMG_H     = 250,
  parameter int         X0        = 84,
  parameter int         Y0        = 115,
  parameter int         ADDR_W    = 17,
  parameter logic [7:0] BG_COLOR  = 8'h00,
  parameter logic [7:0] KEY_COLOR = 8'hFF
) (
  input logic                i_clk2,
  input logic                i_rst_n,
  screen_rom_reader_if.slave bus
);

`ifdef SCREEN_ROM_READER_TRANSP_EN
  localparam bit TRANSP_EN = 1'b1;
`else
  localparam bit TRANSP_EN = 1'b0;
`endif

  localparam logic [9:0]        X_LO      = 10'(X0);
  localparam logic [9:0]        X_HI      = 10'(X0 + IMG_W - 1);
  localparam logic [9:0]        Y_LO      = 10'(Y0);
  localparam logic [9:0]        Y_HI      = 10'(Y0 + IMG_H - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMG_W * IMG_H - 1);

  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_addr_cnt;
  logic              r_hit_a;
  logic              r_hit_b;
  logic              r_frame_done;
  logic [7:0]        r_pixel;
  logic              r_pixel_valid;

  logic              w_in_win;
  logic              w_tick_in;
  logic [ADDR_W-1:0] w_issue_addr;
  logic              w_issue_last;
  logic              w_key_hit;

  assign w_in_win = bus.i_active
                 && (bus.i_x >= X_LO) && (bus.i_x <= X_HI)
                 && (bus.i_y >= Y_LO) && (bus.i_y <= Y_HI);

  assign w_tick_in = bus.i_pix_en && w_in_win;

  // A frame start on the same tick restarts the image, so that pixel gets address 0.
  assign w_issue_addr = bus.i_frame_start ? '0 : r_addr_cnt;
  assign w_issue_last = (w_issue_addr == LAST_ADDR);

  assign w_key_hit = TRANSP_EN && (bus.i_rom_data == KEY_COLOR);

  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addr       <= '0;
      r_addr_cnt   <= '0;
      r_hit_a      <= 1'b0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      if (w_tick_in) begin
        r_addr       <= w_issue_addr;
        r_addr_cnt   <= w_issue_last ? '0 : w_issue_addr + ADDR_W'(1);
        r_frame_done <= w_issue_last;
      end else if (bus.i_frame_start) begin
        r_addr_cnt <= '0;
      end
      if (bus.i_pix_en) begin
        r_hit_a <= w_in_win;
      end
    end
  end

  // hit_b lines up with the ROM's one-clock read latency before the byte is captured.
  always_ff @(posedge i_clk2 or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hit_b       <= 1'b0;
      r_pixel       <= BG_COLOR;
      r_pixel_valid <= 1'b0;
    end else begin
      r_hit_b <= r_hit_a;
      if (r_hit_b && !w_key_hit) begin
        r_pixel       <= bus.i_rom_data;
        r_pixel_valid <= 1'b1;
      end else begin
        r_pixel       <= BG_COLOR;
        r_pixel_valid <= 1'b0;
      end
    end
  end

  assign bus.o_addr        = r_addr;
  assign bus.o_frame_done  = r_frame_done;
  assign bus.o_pixel       = r_pixel;
  assign bus.o_pixel_valid = r_pixel_valid;

endmodule

// File: tb/tb_screen_rom_reader.sv
// Bench for screen_rom_reader: a default-size reader and a small-image reader share one
// scan stimulus and are checked against a pixel-counting reference model.
module tb_screen_rom_reader;

`ifdef SCREEN_ROM_READER_TRANSP_EN
  localparam bit TRANSP = 1'b1;
`else
  localparam bit TRANSP = 1'b0;
`endif

  localparam int W [2] = '{471, 13};
  localparam int H [2] = '{250, 7};
  localparam int X [2] = '{84, 5};
  localparam int Y [2] = '{115, 3};

  logic clk2;
  logic rst_n;

  screen_rom_reader_if #(.ADDR_W(17)) ifA ();
  screen_rom_reader_if #(.ADDR_W(17)) ifB ();

  screen_rom_reader dutA (
    .i_clk2  (clk2),
    .i_rst_n (rst_n),
    .bus     (ifA.slave)
  );

  screen_rom_reader #(
    .IMG_W (13),
    .IMG_H (7),
    .X0    (5),
    .Y0    (3)
  ) dutB (
    .i_clk2  (clk2),
    .i_rst_n (rst_n),
    .bus     (ifB.slave)
  );

  int testCount = 0;
  int failCount = 0;

  int cnt [2];
  int expAddr [2];
  int expPix [2];
  int expValid [2];
  int expDone [2];
  int modelValid [2];
  int obsValid;
  int obsDone;

  initial clk2 = 1'b0;
  always #5 clk2 = ~clk2;

  // ROM contents: address 0 holds 8'h3C, address 5 holds the key colour.
  function automatic logic [7:0] rom_fn(input int a);
    int h;
    if (a == 0) return 8'h3C;
    if (a == 5) return 8'hFF;
    h = (a * 37) + (a >> 8);
    return h[7:0] ^ 8'hA5;
  endfunction

  always @(posedge clk2) begin
    ifA.i_rom_data <= rom_fn(int'(ifA.o_addr));
    ifB.i_rom_data <= rom_fn(int'(ifB.o_addr));
  end

  task automatic checkOutput(input string tag, input int actual, input int expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic driveBus(input bit pix, input bit fs, input bit act, input int x, input int y);
    ifA.i_pix_en = pix; ifA.i_frame_start = fs; ifA.i_active = act;
    ifA.i_x = 10'(x);   ifA.i_y = 10'(y);
    ifB.i_pix_en = pix; ifB.i_frame_start = fs; ifB.i_active = act;
    ifB.i_x = 10'(x);   ifB.i_y = 10'(y);
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      cnt[d] = 0; expAddr[d] = 0; expPix[d] = 0; expValid[d] = 0; expDone[d] = 0;
    end
  endtask

  task automatic pulseFrameStart();
    @(posedge clk2); #1;
    driveBus(0, 1, 0, 0, 0);
    cnt[0] = 0; cnt[1] = 0;
    @(posedge clk2); #1;
    driveBus(0, 0, 0, 0, 0);
  endtask

  // One pixel tick; scan inputs stay put (pix_en low) for the following three clocks.
  task automatic applyStimulus(input bit fs, input bit act, input int x, input int y);
    bit inWin;
    int dat;
    @(posedge clk2); #1;
    driveBus(1, fs, act, x, y);
    for (int d = 0; d < 2; d++) begin
      if (fs) cnt[d] = 0;
      inWin = act && x >= X[d] && x < X[d] + W[d] && y >= Y[d] && y < Y[d] + H[d];
      expDone[d] = 0;
      if (inWin) begin
        expAddr[d] = cnt[d];
        expDone[d] = (cnt[d] == W[d] * H[d] - 1) ? 1 : 0;
        cnt[d] = (cnt[d] + 1) % (W[d] * H[d]);
        dat = int'(rom_fn(expAddr[d]));
        expValid[d] = (TRANSP && dat == 255) ? 0 : 1;
        expPix[d] = (expValid[d] != 0) ? dat : 0;
      end else begin
        expValid[d] = 0;
        expPix[d] = 0;
      end
      modelValid[d] += expValid[d];
    end
    @(posedge clk2); #1;
    driveBus(0, 0, act, x, y);
    checkOutput("addrA", int'(ifA.o_addr), expAddr[0]);
    checkOutput("addrB", int'(ifB.o_addr), expAddr[1]);
    checkOutput("doneA", int'(ifA.o_frame_done), expDone[0]);
    checkOutput("doneB", int'(ifB.o_frame_done), expDone[1]);
    if (ifB.o_frame_done) obsDone++;
    @(posedge clk2);
    @(posedge clk2); #1;
    checkOutput("pixA", int'(ifA.o_pixel), expPix[0]);
    checkOutput("pixB", int'(ifB.o_pixel), expPix[1]);
    checkOutput("validA", int'(ifA.o_pixel_valid), expValid[0]);
    checkOutput("validB", int'(ifB.o_pixel_valid), expValid[1]);
    checkOutput("doneClrA", int'(ifA.o_frame_done), 0);
    checkOutput("doneClrB", int'(ifB.o_frame_done), 0);
    if (ifB.o_pixel_valid) obsValid++;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "AddrA"}, int'(ifA.o_addr), 0);
    checkOutput({tag, "PixA"}, int'(ifA.o_pixel), 0);
    checkOutput({tag, "ValidA"}, int'(ifA.o_pixel_valid), 0);
    checkOutput({tag, "DoneA"}, int'(ifA.o_frame_done), 0);
    checkOutput({tag, "AddrB"}, int'(ifB.o_addr), 0);
    checkOutput({tag, "ValidB"}, int'(ifB.o_pixel_valid), 0);
  endtask

  initial begin
    int x;
    int y;
    bit fs;
    bit act;
    driveBus(0, 0, 0, 0, 0);
    modelReset();
    modelValid[0] = 0; modelValid[1] = 0;
    obsValid = 0; obsDone = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 checkResetState("rst");
    repeat (3) @(posedge clk2);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 10 + i, 20);

    // First image row plus part of the second, then a frame restart at address 500.
    pulseFrameStart();
    for (int c = 84; c <= 555; c++) begin
      applyStimulus(0, 1, c, 115);
      if (c == 84) begin
        checkOutput("firstPix", int'(ifA.o_pixel), 8'h3C);
        checkOutput("firstValid", int'(ifA.o_pixel_valid), 1);
      end
      if (c == 89) begin
        checkOutput("keyPix", int'(ifA.o_pixel), TRANSP ? 8'h00 : 8'hFF);
        checkOutput("keyValid", int'(ifA.o_pixel_valid), TRANSP ? 0 : 1);
      end
      if (c == 554) checkOutput("rowEndAddr", int'(ifA.o_addr), 470);
      if (c == 555) begin
        checkOutput("pastEdgeAddr", int'(ifA.o_addr), 470);
        checkOutput("pastEdgeValid", int'(ifA.o_pixel_valid), 0);
      end
    end
    for (int c = 84; c <= 112; c++) begin
      applyStimulus(0, 1, c, 116);
      if (c == 84) checkOutput("rowWrapAddr", int'(ifA.o_addr), 471);
    end
    applyStimulus(1, 1, 113, 116);
    checkOutput("prioAddr0", int'(ifA.o_addr), 0);
    applyStimulus(0, 1, 114, 116);
    checkOutput("prioAddr1", int'(ifA.o_addr), 1);

    // Whole frame of the small image over a 24x12 raster.
    obsValid = 0; obsDone = 0; modelValid[1] = 0;
    pulseFrameStart();
    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 24; c++)
        applyStimulus(0, 1, c, r);
    checkOutput("frameValidCount", obsValid, modelValid[1]);
    checkOutput("frameDoneCount", obsDone, 1);
    checkOutput("frameLastAddr", int'(ifB.o_addr), W[1] * H[1] - 1);
    applyStimulus(0, 1, X[1], Y[1]);
    checkOutput("frameWrapAddr", int'(ifB.o_addr), 0);

    // Random scan positions around the large image window.
    for (int i = 0; i < 300; i++) begin
      fs  = ($urandom_range(0, 49) == 0);
      act = ($urandom_range(0, 9) != 0);
      x   = X[0] - 3 + int'($urandom_range(0, 476));
      y   = Y[0] - 2 + int'($urandom_range(0, 253));
      applyStimulus(fs, act, x, y);
    end

    // Reset in the middle of an in-window stream.
    for (int c = 200; c < 204; c++) applyStimulus(0, 1, c, 150);
    rst_n = 1'b0;
    #1 checkResetState("midRst");
    modelReset();
    repeat (2) @(posedge clk2);
    #1 rst_n = 1'b1;
    applyStimulus(0, 1, 20, 20);
    applyStimulus(0, 0, 100, 150);
    applyStimulus(0, 1, 600, 400);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
